// File: rtl/sdr_pkg.sv
// Shared definitions for the FTDI receive-path demultiplexer: header layout,
// destination codes and FSM state encoding.
package sdr_pkg;
    localparam int FT_DATA_WIDTH    = 32;
    localparam int IQ_PAIR_WIDTH    = 24;
    localparam int QSTART_BIT_INDEX = 16;
    localparam int LEN_WIDTH        = 16;
    localparam int PKT_CNT_WIDTH    = 16;

    localparam int DEST_BIT = 31;
    localparam int LEN_LSB  = 0;
    localparam int LEN_MSB  = LEN_WIDTH - 1;

    localparam logic DEST_FIFO = 1'b0;
    localparam logic DEST_CPU  = 1'b1;

    typedef enum logic [1:0] {
        HDR     = 2'd0,
        PL_FIFO = 2'd1,
        PL_CPU  = 2'd2
    } state_t;
endpackage

// File: rtl/sel_f2a_if.sv
// FTDI-side write port plus TX-FIFO / CPU-FIFO sink ports of sel_f2a.
interface sel_f2a_if #(
    parameter int FT_DATA_WIDTH = 32,
    parameter int IQ_PAIR_WIDTH = 24
);
    logic [FT_DATA_WIDTH-1:0] data_i;
    logic                     we_i;
    logic                     ready_o;
    logic [IQ_PAIR_WIDTH-1:0] fifo_data_o;
    logic                     fifo_we_o;
    logic                     fifo_full_i;
    logic [FT_DATA_WIDTH-1:0] cpu_data_o;
    logic                     cpu_we_o;
    logic                     cpu_full_i;
    logic                     data_incomming_o;
    logic [15:0]              pkt_cnt_o;
    logic                     pad_err_o;

    modport slave (
        input  data_i, we_i, fifo_full_i, cpu_full_i,
        output ready_o, fifo_data_o, fifo_we_o, cpu_data_o, cpu_we_o,
               data_incomming_o, pkt_cnt_o, pad_err_o
    );

    modport master (
        output data_i, we_i, fifo_full_i, cpu_full_i,
        input  ready_o, fifo_data_o, fifo_we_o, cpu_data_o, cpu_we_o,
               data_incomming_o, pkt_cnt_o, pad_err_o
    );
endinterface

// File: rtl/sel_f2a.sv
// Host-to-application demux: parses a one-word header and routes the payload
// either to the TX IQ FIFO (unpacked to 12-bit I/Q) or unchanged to the CPU FIFO.
module sel_f2a
    import sdr_pkg::*;
#(
    parameter int FT_DATA_WIDTH    = sdr_pkg::FT_DATA_WIDTH,
    parameter int IQ_PAIR_WIDTH    = sdr_pkg::IQ_PAIR_WIDTH,
    parameter int QSTART_BIT_INDEX = sdr_pkg::QSTART_BIT_INDEX,
    parameter int LEN_WIDTH        = sdr_pkg::LEN_WIDTH
) (
    input  logic       clk_i,
    input  logic       reset,
    sel_f2a_if.slave   bus
);
    state_t                 r_state, w_state_nxt;
    logic [LEN_WIDTH-1:0]   r_remain;
    logic [15:0]            r_pkt_cnt;
    logic                   r_pad_err;
    logic                   r_fifo_we, r_cpu_we;
    logic [IQ_PAIR_WIDTH-1:0] r_fifo_data;
    logic [FT_DATA_WIDTH-1:0] r_cpu_data;

    logic                   w_ready, w_xfer, w_last, w_pad_bad;
    logic [LEN_WIDTH-1:0]   w_len;

    assign w_len     = bus.data_i[LEN_MSB:LEN_LSB];
    assign w_xfer    = bus.we_i & w_ready;
    assign w_last    = (r_remain == '0);
    assign w_pad_bad = (bus.data_i[31:28] != 4'h0) || (bus.data_i[15:12] != 4'h0);

    always_comb begin
        w_ready     = 1'b1;
        w_state_nxt = r_state;
        unique case (r_state)
            HDR: begin
                if (w_xfer && w_len != '0)
                    w_state_nxt = (bus.data_i[DEST_BIT] == DEST_CPU) ? PL_CPU : PL_FIFO;
            end
            PL_FIFO: begin
                w_ready = ~bus.fifo_full_i;
                if (w_xfer && w_last) w_state_nxt = HDR;
            end
            PL_CPU: begin
                w_ready = ~bus.cpu_full_i;
                if (w_xfer && w_last) w_state_nxt = HDR;
            end
            default: w_state_nxt = HDR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_state     <= HDR;
            r_remain    <= '0;
            r_pkt_cnt   <= '0;
            r_pad_err   <= 1'b0;
            r_fifo_we   <= 1'b0;
            r_cpu_we    <= 1'b0;
            r_fifo_data <= '0;
            r_cpu_data  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_fifo_we <= 1'b0;
            r_cpu_we  <= 1'b0;
            if (w_xfer) begin
                unique case (r_state)
                    HDR: begin
                        if (w_len == '0) r_pkt_cnt <= r_pkt_cnt + 16'd1;
                        else             r_remain  <= w_len - 1'b1;
                    end
                    PL_FIFO: begin
                        r_fifo_we   <= 1'b1;
                        r_fifo_data <= {bus.data_i[QSTART_BIT_INDEX+11:QSTART_BIT_INDEX],
                                        bus.data_i[11:0]};
                        if (w_pad_bad) r_pad_err <= 1'b1;
                    end
                    PL_CPU: begin
                        r_cpu_we   <= 1'b1;
                        r_cpu_data <= bus.data_i;
                    end
                    default: ;
                endcase
                // Payload bookkeeping shared by both sinks.
                if (r_state != HDR) begin
                    if (w_last) r_pkt_cnt <= r_pkt_cnt + 16'd1;
                    else        r_remain  <= r_remain - 1'b1;
                end
            end
        end
    end

    assign bus.ready_o          = w_ready;
    assign bus.data_incomming_o = (r_state != HDR);
    assign bus.fifo_we_o        = r_fifo_we;
    assign bus.fifo_data_o      = r_fifo_data;
    assign bus.cpu_we_o         = r_cpu_we;
    assign bus.cpu_data_o       = r_cpu_data;
    assign bus.pkt_cnt_o        = r_pkt_cnt;
    assign bus.pad_err_o        = r_pad_err;
endmodule

// File: tb/tb_sel_f2a.sv
// Directed bench for sel_f2a: packet routing, IQ unpacking, backpressure,
// sticky pad error and mid-packet reset.
module tb_sel_f2a;
    logic clk_i = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   fifo_pulses = 0;
    int   cpu_pulses  = 0;

    sel_f2a_if #(.FT_DATA_WIDTH(32), .IQ_PAIR_WIDTH(24)) bus ();

    sel_f2a dut (
        .clk_i (clk_i),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (bus.fifo_we_o) fifo_pulses <= fifo_pulses + 1;
        if (bus.cpu_we_o)  cpu_pulses  <= cpu_pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle; afterwards outputs reflect the edge just taken.
    task automatic step(input logic we, input logic [31:0] d);
        bus.we_i   = we;
        bus.data_i = d;
        @(posedge clk_i);
        #1;
        bus.we_i = 1'b0;
    endtask

    int f0;

    initial begin
        reset = 1'b1;
        bus.we_i = 1'b0; bus.data_i = '0;
        bus.fifo_full_i = 1'b0; bus.cpu_full_i = 1'b0;
        @(posedge clk_i); #1;
        chk("rst_ready", bus.ready_o, 1);
        chk("rst_inc", bus.data_incomming_o, 0);
        chk("rst_pkt", bus.pkt_cnt_o, 0);
        chk("rst_pad", bus.pad_err_o, 0);
        chk("rst_fwe", bus.fifo_we_o, 0);
        chk("rst_cwe", bus.cpu_we_o, 0);
        chk("rst_fdata", bus.fifo_data_o, 0);
        chk("rst_cdata", bus.cpu_data_o, 0);
        // reset dominates a simultaneous header write
        step(1'b1, 32'h8000_0003);
        chk("rst_dom_inc", bus.data_incomming_o, 0);
        reset = 1'b0;

        // FIFO packet of 3, back-to-back
        step(1'b1, 32'h0000_0003);
        chk("t1_hdr_fwe", bus.fifo_we_o, 0);
        chk("t1_hdr_inc", bus.data_incomming_o, 1);
        step(1'b1, 32'h0123_0456);
        chk("t1_w1_we", bus.fifo_we_o, 1);
        chk("t1_w1_d", bus.fifo_data_o, 32'h123456);
        step(1'b1, 32'h0ABC_0DEF);
        chk("t1_w2_we", bus.fifo_we_o, 1);
        chk("t1_w2_d", bus.fifo_data_o, 32'hABCDEF);
        step(1'b1, 32'h0001_0002);
        chk("t1_w3_we", bus.fifo_we_o, 1);
        chk("t1_w3_d", bus.fifo_data_o, 32'h001002);
        chk("t1_pkt", bus.pkt_cnt_o, 1);
        chk("t1_inc", bus.data_incomming_o, 0);
        chk("t1_pad", bus.pad_err_o, 0);
        step(1'b0, 32'h0);
        chk("t1_idle_fwe", bus.fifo_we_o, 0);

        // CPU packet of 2
        step(1'b1, 32'h8000_0002);
        chk("t2_hdr_inc", bus.data_incomming_o, 1);
        chk("t2_hdr_cwe", bus.cpu_we_o, 0);
        step(1'b1, 32'hDEAD_BEEF);
        chk("t2_w1_we", bus.cpu_we_o, 1);
        chk("t2_w1_d", bus.cpu_data_o, 32'hDEAD_BEEF);
        chk("t2_w1_fwe", bus.fifo_we_o, 0);
        chk("t2_w1_inc", bus.data_incomming_o, 1);
        step(1'b1, 32'hCAFE_F00D);
        chk("t2_w2_we", bus.cpu_we_o, 1);
        chk("t2_w2_d", bus.cpu_data_o, 32'hCAFE_F00D);
        chk("t2_w2_fwe", bus.fifo_we_o, 0);
        chk("t2_pkt", bus.pkt_cnt_o, 2);
        chk("t2_inc", bus.data_incomming_o, 0);

        // zero-length header, then a 1-word CPU packet
        step(1'b1, 32'h0000_0000);
        chk("t3_z_pkt", bus.pkt_cnt_o, 3);
        chk("t3_z_inc", bus.data_incomming_o, 0);
        step(1'b1, 32'h8000_0001);
        chk("t3_z_nowr", {bus.fifo_we_o, bus.cpu_we_o}, 0);
        step(1'b1, 32'h1111_1111);
        chk("t3_cwe", bus.cpu_we_o, 1);
        chk("t3_cd", bus.cpu_data_o, 32'h1111_1111);
        chk("t3_pkt", bus.pkt_cnt_o, 4);

        // FIFO packet of 4 with backpressure after word 2
        step(1'b0, 32'h0);
        f0 = fifo_pulses;
        step(1'b1, 32'h0000_0004);
        step(1'b1, 32'h0001_0001);
        step(1'b1, 32'h0002_0002);
        chk("t4_w2_d", bus.fifo_data_o, 32'h002002);
        bus.fifo_full_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.we_i = 1'b1; bus.data_i = 32'h0003_0003;
            #1;
            chk("t4_full_ready", bus.ready_o, 0);
            @(posedge clk_i); #1;
            chk("t4_full_nowe", bus.fifo_we_o, 0);
        end
        bus.fifo_full_i = 1'b0;
        #1;
        chk("t4_rel_ready", bus.ready_o, 1);
        step(1'b1, 32'h0003_0003);
        chk("t4_w3_d", bus.fifo_data_o, 32'h003003);
        step(1'b1, 32'h0004_0004);
        chk("t4_w4_d", bus.fifo_data_o, 32'h004004);
        chk("t4_pkt", bus.pkt_cnt_o, 5);
        step(1'b0, 32'h0);
        chk("t4_pulses", fifo_pulses - f0, 4);

        // pad error is sticky
        step(1'b1, 32'h0000_0001);
        step(1'b1, 32'hF000_0000);
        chk("t5_pad", bus.pad_err_o, 1);
        chk("t5_d", bus.fifo_data_o, 0);
        step(1'b1, 32'h0000_0001);
        step(1'b1, 32'h0001_0002);
        chk("t5_good_d", bus.fifo_data_o, 32'h001002);
        chk("t5_pad_sticky", bus.pad_err_o, 1);
        chk("t5_pkt", bus.pkt_cnt_o, 7);

        // reset mid CPU packet
        step(1'b1, 32'h8000_0005);
        step(1'b1, 32'hAAAA_0001);
        step(1'b1, 32'hAAAA_0002);
        reset = 1'b1;
        step(1'b0, 32'h0);
        reset = 1'b0;
        chk("t6_pkt0", bus.pkt_cnt_o, 0);
        chk("t6_pad0", bus.pad_err_o, 0);
        chk("t6_inc0", bus.data_incomming_o, 0);
        chk("t6_ready", bus.ready_o, 1);
        f0 = cpu_pulses;
        step(1'b1, 32'h8000_0001);
        chk("t6_hdr_inc", bus.data_incomming_o, 1);
        step(1'b1, 32'h0000_0055);
        chk("t6_cwe", bus.cpu_we_o, 1);
        chk("t6_cd", bus.cpu_data_o, 32'h55);
        chk("t6_pkt1", bus.pkt_cnt_o, 1);
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        chk("t6_pulses", cpu_pulses - f0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
